// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills instruction memory and holds the core in reset until verified
module imem_loader #(
    parameter int MEM_WORDS = 101
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    input  logic        i_reload,
    output logic        o_we,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_done,
    output logic        o_error,
    output logic        o_cpu_rst
);
    localparam int IW = $clog2(MEM_WORDS + 1);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

    state_t          state, next;
    logic [7:0]      len_lo, csum;
    logic [15:0]     len, n;
    logic [1:0]      lane;
    logic [IW-1:0]   idx;
    logic [2:0][7:0] wb;
    logic            accept, last, reload_ok;

    assign o_byte_ready = !i_rst && (state == LEN0 || state == LEN1 || state == DATA || state == CSUM);
    assign accept       = i_byte_valid && o_byte_ready;
    assign reload_ok    = i_reload && (state == DONE || state == ERROR);
    assign n            = {i_byte, len_lo};
    assign last         = lane == 2'd3 && 32'(idx) + 32'd1 == 32'(len);
    assign o_done       = state == DONE;
    assign o_error      = state == ERROR;
    assign o_cpu_rst    = state != DONE;

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= LEN0;
        else       state <= next;
    end

    // next-state: advance only on accepted bytes, reload only from terminal states
    always_comb begin
        next = state;
        if (accept) begin
            if (state == LEN0)              next = LEN1;
            else if (state == LEN1)         next = 32'(n) > 32'(MEM_WORDS) ? ERROR : n == 16'd0 ? CSUM : DATA;
            else if (state == DATA && last) next = CSUM;
            else if (state == CSUM)         next = i_byte == csum ? DONE : ERROR;
        end
        if (reload_ok) next = LEN0;
    end

    // datapath: length capture, word assembly, checksum and write strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
            csum    <= '0;
            idx     <= '0;
            lane    <= '0;
            len_lo  <= '0;
            len     <= '0;
            wb      <= '0;
        end else begin
            o_we <= 1'b0;
            if (reload_ok) begin
                idx  <= '0;
                lane <= '0;
                csum <= '0;
            end else if (accept) begin
                if (state == LEN0) len_lo <= i_byte;
                if (state == LEN1) len <= n;
                if (state == DATA) begin
                    csum <= csum ^ i_byte;
                    lane <= lane + 2'd1;
                    if (lane == 2'd3) begin
                        o_we    <= 1'b1;
                        o_wdata <= {i_byte, wb[2], wb[1], wb[0]};
                        o_waddr <= 32'({idx, 2'b00});
                        idx     <= idx + 1'b1;
                    end else begin
                        wb[lane] <= i_byte;
                    end
                end
            end
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory the fetch stage reads. It accepts a byte stream (valid/ready) carrying a word count, little-endian instruction words and an XOR checksum. It assembles 32-bit words and issues one write per word to the writable instruction-memory port. It holds the core in reset until a complete, checksum-valid image has been written.

## Interface
- MEM_WORDS, default 101: instruction-memory depth in 32-bit words; maximum accepted word count.
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_byte_valid  input  1  stream byte present on i_byte.
- i_byte  input  8  stream byte.
- o_byte_ready  output  1  loader accepts i_byte this cycle.
- i_reload  input  1  one-cycle request to start a new load; honoured only in DONE or ERROR.
- o_we  output  1  instruction-memory write strobe, one cycle per word.
- o_waddr  output  32  byte address of the written word; always word-aligned, so [1:0]=0.
- o_wdata  output  32  assembled instruction word.
- o_done  output  1  image loaded and verified.
- o_error  output  1  load rejected.
- o_cpu_rst  output  1  core reset request; high until DONE.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then N×4 data bytes, each word least-significant byte first, then CSUM.
- CSUM is the XOR of all data bytes only; the length bytes are excluded.
- A byte is accepted on any rising edge where i_byte_valid && o_byte_ready.
- States:
  - LEN0 (reset state): accept LEN_LO, go to LEN1.
  - LEN1: accept LEN_HI, then branch on N:
    - N > MEM_WORDS: go to ERROR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: accept bytes into byte lane cnt[1:0] and XOR each into the running checksum.
    - On the 4th byte of a word, register the word, pulse o_we, and increment the word index.
    - After word N-1 is written, go to CSUM.
  - CSUM: accept one byte. Go to DONE if it equals the running XOR, otherwise to ERROR.
  - DONE: o_done=1, o_cpu_rst=0, o_byte_ready=0.
  - ERROR: o_error=1, o_cpu_rst=1, o_byte_ready=0.
- o_byte_ready is 1 in LEN0, LEN1, DATA and CSUM, and 0 in DONE and ERROR.
- i_reload in DONE or ERROR:
  - Clears the word index, byte lane, checksum, o_done and o_error.
  - Raises o_cpu_rst and returns to LEN0.
  - Ignored in all other states.
- Bytes presented while o_byte_ready=0 are not consumed; the producer holds them.
- Word index width is clog2(MEM_WORDS+1). o_waddr = index << 2, zero-extended to 32 bits.
- A partial word never produces a write.

## Timing
- Reset values (forced on the first edge with i_rst=1, including mid-load):
  - state=LEN0
  - o_we=0, o_waddr=0, o_wdata=0
  - o_done=0, o_error=0, o_cpu_rst=1
  - checksum=0, word index=0, byte lane=0
- While i_rst=1, o_byte_ready=0 and no byte is accepted.
- o_we is high exactly one cycle, the cycle after the 4th byte of a word is accepted. o_waddr and o_wdata are valid in that same cycle and hold their values until the next write.
- Full throughput is one byte per cycle with no stall. A byte, including CSUM, may be accepted in the same cycle o_we is high.
- o_done or o_error rises the cycle after CSUM is accepted. o_cpu_rst falls in that same cycle (DONE only).
- For N > MEM_WORDS, o_error rises the cycle after LEN_HI is accepted, and no write occurs.
- Gaps in i_byte_valid stall the FSM with no state, lane or checksum change.
- The cycle after i_reload is sampled: state=LEN0, o_done=0, o_error=0, o_cpu_rst=1. o_byte_ready=1 from that cycle on.

## Test plan
- Nominal load, one byte per cycle. Stream: 02 00 | 93 00 50 00 | 13 01 A0 00 | 71.
  - Required: o_we at waddr 0x0 with 0x00500093, then at 0x4 with 0x00A00113.
  - Then o_done=1, o_cpu_rst=0, o_byte_ready=0.
- Empty image. Stream: 00 00 00.
  - Required: no o_we, o_done=1. With CSUM 01 instead: o_error=1, o_cpu_rst=1.
- Oversize image. Stream: 66 00 (N=102).
  - Required: o_error=1 the next cycle, o_byte_ready=0, no o_we.
- Checksum mismatch: nominal stream with last byte 70.
  - Required: both writes occur, then o_error=1, o_done=0, o_cpu_rst=1.
- Backpressure and reset. Nominal stream with i_byte_valid toggled randomly.
  - Required: identical writes and o_done.
  - Assert i_rst after 5 data bytes, then restart with the nominal stream: exactly two writes, correct data, o_done=1.
- Reload: after ERROR, pulse i_reload and send the nominal stream.
  - Required: o_error clears next cycle, o_cpu_rst stays 1, writes to 0x0 and 0x4, then o_done=1.
  - i_reload pulsed mid-DATA has no effect.
